// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer. Synchronises rs232_rx, starts the
// baud timing block on a start edge, assembles a byte LSB first from the
// mid-bit strobes, checks the stop bit and hands the byte to a consumer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   rs232_rx     raw serial line (idles high)
//   rx_sel_data  mid-bit strobe from the timing block
//   rx_num       bit index from the timing block (0 start, 1..8 data,
//                9 stop, 10 end of frame)
//   rx_en        one-cycle pulse starting the timing block
//   rx_data      received byte, stable while rx_valid=1
//   rx_valid     byte available; taken when rx_valid & rx_ready
//   rx_ready     consumer ready
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: byte lost because the buffer was full
//   busy         receiver is inside a frame
module uart_rx_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       rx_sel_data,
  input  logic [3:0] rx_num,
  output logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [NS-1:0] sync_q;
  logic          line_s;
  logic          line_prev;
  logic          fall;
  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          data_hit;
  logic          stop_hit;
  logic          deliver;

  assign line_s = sync_q[NS-1];
  assign fall   = line_prev & ~line_s;

  // rx_num 1..8 maps to shreg bits 0..7; the 3-bit
  // subtraction wraps 8 onto 7.
  assign bit_idx  = rx_num[2:0] - 3'd1;
  assign data_hit = (state == DATA) & rx_sel_data
                  & (rx_num >= 4'd1) & (rx_num <= 4'd8);
  assign stop_hit = (state == STOP) & rx_sel_data
                  & (rx_num == 4'd9);
  assign deliver  = stop_hit & (line_s | ~DROP_BAD_FRAME);

  // Combinational so the pulse lives only in the IDLE cycle
  // that sees the edge.
  assign rx_en = (state == IDLE) & fall;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      line_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[NS-2:0], rs232_rx};
      line_prev <= line_s;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (fall) state_nx = START;
      end
      (state == START): begin
        if (rx_sel_data && rx_num == 4'd0)
          state_nx = line_s ? DRAIN : DATA;
      end
      (state == DATA): begin
        if (rx_sel_data && rx_num == 4'd8)
          state_nx = STOP;
      end
      (state == STOP): begin
        if (stop_hit) state_nx = DRAIN;
      end
      (state == DRAIN): begin
        if (rx_num == 4'd10) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= 8'h00;
    end else begin
      state <= state_nx;
      if (data_hit) shreg[bit_idx] <= line_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_hit & ~line_s;
      overrun   <= deliver & rx_valid & ~rx_ready;
      if (deliver) begin
        // A byte taken in this same cycle frees the slot.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: bench for uart_rx_ctrl with a behavioural baud timing
// block, a serial line driver and a byte-level delivery model.
module tb_uart_rx_ctrl;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs232_rx = 1'b1;
  logic       rx_sel_data = 1'b0;
  logic [3:0] rx_num = 4'd0;
  logic       rx_ready = 1'b0;

  logic       rx_en, rx_valid, frame_err, overrun, busy;
  logic [7:0] rx_data;
  logic       en0, v0, fe0, ov0, busy0;
  logic [7:0] d0;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  uart_rx_ctrl #(.SYNC_STAGES(2), .DROP_BAD_FRAME(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx),
    .rx_sel_data(rx_sel_data), .rx_num(rx_num),
    .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  uart_rx_ctrl #(.SYNC_STAGES(2), .DROP_BAD_FRAME(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx),
    .rx_sel_data(rx_sel_data), .rx_num(rx_num),
    .rx_en(en0), .rx_data(d0), .rx_valid(v0),
    .rx_ready(rx_ready), .frame_err(fe0),
    .overrun(ov0), .busy(busy0)
  );

  // Baud timing block: strobe mid-bit, index advances after
  // each strobe, cleared the cycle after reaching 10.
  logic run = 1'b0;
  int   cnt = 0;
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        run <= 1'b0; cnt <= 0;
        rx_num <= 4'd0; rx_sel_data <= 1'b0;
      end else begin
        rx_sel_data <= 1'b0;
        if (rx_en) begin
          run <= 1'b1; cnt <= 0; rx_num <= 4'd0;
        end else if (run) begin
          if (rx_num == 4'd10) begin
            run <= 1'b0; cnt <= 0; rx_num <= 4'd0;
          end else begin
            cnt <= (cnt == BIT - 1) ? 0 : cnt + 1;
            if (cnt == BIT / 2 - 1) rx_sel_data <= 1'b1;
            if (rx_sel_data) rx_num <= rx_num + 4'd1;
          end
        end
      end
    end
  end

  // Observation of both DUTs, sampled on the falling edge.
  int cyc = 0, stop_cyc = 0, ov_cyc = -1, lat = -1;
  int n_en = 0, n_fe = 0, n_ov = 0, n_vc = 0;
  int n_en0 = 0, n_fe0 = 0, n_ov0 = 0;
  logic pv = 1'b0;
  logic [7:0] acc[$];
  logic [7:0] acc0[$];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (rx_sel_data && rx_num == 4'd9) stop_cyc = cyc;
        if (rx_valid && !pv) lat = cyc - stop_cyc;
        if (rx_en) n_en++;
        if (frame_err) n_fe++;
        if (overrun) begin n_ov++; ov_cyc = cyc; end
        if (rx_valid) n_vc++;
        if (rx_valid && rx_ready) acc.push_back(rx_data);
        if (en0) n_en0++;
        if (fe0) n_fe0++;
        if (ov0) n_ov0++;
        if (v0 && rx_ready) acc0.push_back(d0);
      end
      pv = rx_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_en = 0; n_fe = 0; n_ov = 0; n_vc = 0;
    n_en0 = 0; n_fe0 = 0; n_ov0 = 0;
    lat = -1; ov_cyc = -1;
    acc.delete(); acc0.delete();
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop, input int nbits);
    rs232_rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < nbits; i++) begin
      rs232_rx = d[i];
      tick(BIT);
    end
    if (nbits == 8) begin
      rs232_rx = stop;
      tick(BIT);
      rs232_rx = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || busy0 || run) && k < 40 * BIT) begin
      tick(1);
      k++;
    end
    checks++;
    if (busy || busy0 || run) begin
      failures++;
      $display("FAIL idle_timeout busy=%0b run=%0b required 0", busy, run);
    end
    tick(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({rx_en, rx_valid, frame_err, overrun, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required 00000",
               {rx_en, rx_valid, frame_err, overrun, busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h required 00", rx_data);
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_basic();
    rx_ready = 1'b1;
    tick(1);
    clr_mon();
    send_frame(8'h55, 1'b1, 8);
    wait_idle();
    checks++;
    if (n_en !== 1 || n_en0 !== 1) begin
      failures++;
      $display("FAIL basic_rx_en got=%0d/%0d required 1", n_en, n_en0);
    end
    checks++;
    if (acc.size() !== 1 || rx_data !== 8'h55) begin
      failures++;
      $display("FAIL basic_data got=%h n=%0d required 55", rx_data, acc.size());
    end
    checks++;
    if (n_vc !== 1) begin
      failures++;
      $display("FAIL basic_valid_cycles got=%0d required 1", n_vc);
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL basic_latency got=%0d required 1", lat);
    end
    checks++;
    if (n_fe !== 0 || n_ov !== 0) begin
      failures++;
      $display("FAIL basic_errs got=%0d/%0d required 0/0", n_fe, n_ov);
    end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    tick(1);
    clr_mon();
    send_frame(8'hA3, 1'b1, 8);
    send_frame(8'h0F, 1'b1, 8);
    wait_idle();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA3) begin
      failures++;
      $display("FAIL ovr_hold got=%b/%h required 1/a3", rx_valid, rx_data);
    end
    checks++;
    if (n_ov !== 1 || n_ov0 !== 1) begin
      failures++;
      $display("FAIL ovr_count got=%0d/%0d required 1", n_ov, n_ov0);
    end
    checks++;
    if (ov_cyc !== stop_cyc + 1) begin
      failures++;
      $display("FAIL ovr_timing got=%0d required %0d", ov_cyc, stop_cyc + 1);
    end
    checks++;
    if (n_en !== 2) begin
      failures++;
      $display("FAIL ovr_rx_en got=%0d required 2", n_en);
    end
    rx_ready = 1'b1;
    tick(2);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovr_release got=%b required 0", rx_valid);
    end
    checks++;
    if (acc.size() !== 1 || acc[0] !== 8'hA3) begin
      failures++;
      $display("FAIL ovr_accepted n=%0d required 1 byte a3", acc.size());
    end
  endtask

  task automatic test_bad_frame();
    rx_ready = 1'b1;
    tick(1);
    clr_mon();
    send_frame(8'hC4, 1'b0, 8);
    tick(BIT);
    wait_idle();
    checks++;
    if (n_fe !== 1 || n_fe0 !== 1) begin
      failures++;
      $display("FAIL bad_frame_err got=%0d/%0d required 1", n_fe, n_fe0);
    end
    checks++;
    if (n_vc !== 0 || acc.size() !== 0) begin
      failures++;
      $display("FAIL bad_drop got=%0d cycles required 0", n_vc);
    end
    checks++;
    if (acc0.size() !== 1 || d0 !== 8'hC4) begin
      failures++;
      $display("FAIL bad_keep got=%h n=%0d required c4", d0, acc0.size());
    end
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    tick(1);
    clr_mon();
    rs232_rx = 1'b0;
    tick(BIT / 4);
    rs232_rx = 1'b1;
    wait_idle();
    checks++;
    if (n_en !== 1 || n_vc !== 0 || n_fe !== 0) begin
      failures++;
      $display("FAIL glitch got en=%0d vc=%0d fe=%0d required 1/0/0",
               n_en, n_vc, n_fe);
    end
    clr_mon();
    send_frame(8'h7E, 1'b1, 8);
    wait_idle();
    checks++;
    if (acc.size() !== 1 || rx_data !== 8'h7E) begin
      failures++;
      $display("FAIL glitch_next got=%h n=%0d required 7e", rx_data, acc.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    rx_ready = 1'b0;
    tick(1);
    clr_mon();
    send_frame(a, 1'b1, 8);
    wait_idle();
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== a) begin
      failures++;
      $display("FAIL b2b_first got=%b/%h required 1/%h", rx_valid, rx_data, a);
    end
    fork
      send_frame(b, 1'b1, 8);
      begin
        int k;
        k = 0;
        while (!(rx_sel_data && rx_num == 4'd9) && k < 12 * BIT) begin
          @(negedge clk);
          k++;
        end
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== b || overrun !== 1'b0) begin
          failures++;
          $display("FAIL b2b_swap got=%b/%h/%b required 1/%h/0",
                   rx_valid, rx_data, overrun, b);
        end
      end
    join
    wait_idle();
    checks++;
    if (n_ov !== 0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after got ov=%0d v=%b required 0/0", n_ov, rx_valid);
    end
    checks++;
    if (acc.size() !== 1 || acc[0] !== b) begin
      failures++;
      $display("FAIL b2b_accepted n=%0d required 1 byte %h", acc.size(), b);
    end
  endtask

  task automatic test_midreset();
    int k;
    rx_ready = 1'b1;
    tick(1);
    send_frame(8'h99, 1'b1, 3);
    k = 0;
    while (rx_num != 4'd4 && k < BIT) begin
      tick(1);
      k++;
    end
    checks++;
    if (rx_num !== 4'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup got num=%0d busy=%b required 4/1", rx_num, busy);
    end
    #3 rst_n = 1'b0;
    rs232_rx = 1'b1;
    #1;
    checks++;
    if ({rx_en, rx_valid, frame_err, overrun, busy} !== 5'b0
        || rx_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_async got=%b/%h required 00000/00",
               {rx_en, rx_valid, frame_err, overrun, busy}, rx_data);
    end
    clr_mon();
    tick(5);
    rst_n = 1'b1;
    tick(12 * BIT);
    checks++;
    if (n_en !== 0 || n_fe !== 0 || n_vc !== 0) begin
      failures++;
      $display("FAIL mid_quiet got en=%0d fe=%0d vc=%0d required 0",
               n_en, n_fe, n_vc);
    end
    send_frame(8'h3C, 1'b1, 8);
    wait_idle();
    checks++;
    if (acc.size() !== 1 || rx_data !== 8'h3C) begin
      failures++;
      $display("FAIL mid_next got=%h n=%0d required 3c", rx_data, acc.size());
    end
  endtask

  // Byte-level model: one buffer slot, consumer readiness
  // held constant across each frame.
  task automatic test_random();
    logic [7:0] exp[$];
    logic [7:0] d, held;
    logic stop, r, full;
    int efe, eov;
    full = 1'b0; held = 8'h00; efe = 0; eov = 0;
    rx_ready = 1'b1;
    tick(3);
    clr_mon();
    for (int f = 0; f < 14; f++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      rx_ready = r;
      if (r && full) begin
        exp.push_back(held);
        full = 1'b0;
      end
      tick(2);
      send_frame(d, stop, 8);
      if (!stop) tick(BIT);
      wait_idle();
      if (!stop) efe++;
      else if (full) eov++;
      else if (r) exp.push_back(d);
      else begin
        full = 1'b1;
        held = d;
      end
    end
    rx_ready = 1'b1;
    if (full) exp.push_back(held);
    tick(3);
    checks++;
    if (n_fe !== efe || n_ov !== eov) begin
      failures++;
      $display("FAIL rand_errs got fe=%0d ov=%0d required %0d/%0d",
               n_fe, n_ov, efe, eov);
    end
    checks++;
    if (acc.size() !== exp.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d required %0d", acc.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (acc[i] !== exp[i]) begin
          failures++;
          $display("FAIL rand_byte%0d got=%h required %h", i, acc[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_bad_frame();
    test_glitch();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
